// File: rtl/rs485_dir_ctrl.sv
// Half-duplex direction sequencer for an RS-422/485 transceiver.
// Sits between a valid/ready byte source and a UART transmitter. It raises
// the driver enable a fixed setup time before the first byte of a burst and
// keeps the bus driven until the UART has gone idle plus a turnaround time.
// A byte that arrives during the turnaround resumes sending without a new
// setup period.

module rs485_dir_ctrl #(
    parameter int SETUP_CYCLES = 16,
    parameter int HOLD_CYCLES  = 32,
    parameter bit RX_DURING_TX = 1'b0,
    parameter bit TERM_EN      = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       tx_busy,
    output logic       rs422_re_n,
    output logic       rs422_de,
    output logic       rs422_te,
    output logic       dir_busy
);

    localparam int MAX_CYCLES = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             de_q, de_d;
    logic             busy_q, busy_d;
    logic             send_active;

    // Next-state and counter: the counter is loaded on entry to SETUP/HOLD
    // and counts down to zero; a new byte in HOLD beats counter expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SEND: begin
                if (!in_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (in_valid) begin
                    state_d = ST_SEND;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin controls are decoded from the next state so they toggle together
    // with the state register rather than one cycle behind it.
    always_comb begin
        de_d   = (state_d != ST_IDLE);
        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and registered pin outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            de_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            de_q    <= de_d;
            busy_q  <= busy_d;
        end
    end

    // Pass-through is only open in SEND; reset also closes it so that no
    // handshake can complete during the reset cycle itself.
    assign send_active = (state_q == ST_SEND) && !reset;
    assign out_data    = in_data;
    assign out_valid   = in_valid && send_active;
    assign in_ready    = out_ready && send_active;

    assign rs422_de    = de_q;
    assign rs422_re_n  = RX_DURING_TX ? 1'b0 : de_q;
    assign rs422_te    = TERM_EN;
    assign dir_busy    = busy_q;

endmodule

// File: tb/tb_rs485_dir_ctrl.sv
// Bench for rs485_dir_ctrl: a primary instance (no echo, no termination) and
// a second instance (echo and termination enabled) share all inputs.

module tb_rs485_dir_ctrl;

    localparam int SETUP = 16;
    localparam int HOLD  = 32;

    typedef struct {
        logic       in_valid;
        logic       out_ready;
        logic       tx_busy;
        logic [7:0] data;
        logic       exp_out_valid;
        logic       exp_in_ready;
        logic       exp_de;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready;
    logic       tx_busy;

    logic       in_ready0, out_valid0, re_n0, de0, te0, dir_busy0;
    logic [7:0] out_data0;
    logic       in_ready1, out_valid1, re_n1, de1, te1, dir_busy1;
    logic [7:0] out_data1;

    logic       uart_en = 1'b0;
    logic       man_ready = 1'b0;
    logic       man_busy = 1'b0;
    logic       model_ready;
    logic       model_busy;
    int         tx_len = 100;
    int         stall_len = 0;

    logic [7:0] exp_q [$];
    int         delivered = 0;
    int         passed = 0;
    int         total = 0;

    logic       mon_en = 1'b0;
    logic       prev_de = 1'b0;
    int         mon_err = 0;
    int         de_rises = 0;
    int         de_falls = 0;

    vec_t       vecs [10];

    assign out_ready = uart_en ? model_ready : man_ready;
    assign tx_busy   = uart_en ? model_busy  : man_busy;

    always #5 clk = ~clk;

    rs485_dir_ctrl #(
        .SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .RX_DURING_TX(1'b0), .TERM_EN(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .tx_busy(tx_busy),
        .rs422_re_n(re_n0), .rs422_de(de0), .rs422_te(te0), .dir_busy(dir_busy0)
    );

    rs485_dir_ctrl #(
        .SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .RX_DURING_TX(1'b1), .TERM_EN(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .tx_busy(tx_busy),
        .rs422_re_n(re_n1), .rs422_de(de1), .rs422_te(te1), .dir_busy(dir_busy1)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid  = v.in_valid;
        in_data   = v.data;
        man_ready = v.out_ready;
        man_busy  = v.tx_busy;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        @(negedge clk);
        checkOutput($sformatf("vec%0d_out_valid", idx), out_valid0, v.exp_out_valid);
        checkOutput($sformatf("vec%0d_in_ready", idx), in_ready0, v.exp_in_ready);
        checkOutput($sformatf("vec%0d_out_data", idx), out_data0, v.data);
        checkOutput($sformatf("vec%0d_de", idx), de0, v.exp_de);
        @(posedge clk);
        #1;
    endtask

    task automatic waitHandshake(input string name);
        int k = 0;
        @(negedge clk);
        while (!(in_valid && in_ready0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) checkOutput({name, "_hs_timeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        exp_q.push_back(b);
        waitHandshake($sformatf("byte_%02h", b));
    endtask

    task automatic waitBusyFall(input string name);
        int k = 0;
        @(negedge clk);
        while (tx_busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) checkOutput({name, "_busy_timeout"}, 0, 1);
    endtask

    // Counts edges from the one that first samples tx_busy low up to DE low.
    task automatic measureHold(output int k);
        @(posedge clk);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (de0 && k < 100);
    endtask

    task automatic waitIdle(input string name);
        int k = 0;
        while (dir_busy0 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 400) checkOutput({name, "_idle_timeout"}, 0, 1);
    endtask

    // UART transmitter model: pops the scoreboard on each handshake, then
    // holds tx_busy for tx_len cycles and out_ready low for stall_len more.
    initial begin : uart_model
        logic hs;
        logic [7:0] exp_b;
        int busy_left;
        int stall_left;
        model_ready = 1'b1;
        model_busy  = 1'b0;
        busy_left   = 0;
        stall_left  = 0;
        forever begin
            @(negedge clk);
            hs = uart_en && out_valid0 && out_ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checkOutput("sb_unexpected_byte", out_data0, -1);
                end else begin
                    exp_b = exp_q.pop_front();
                    checkOutput("sb_data", out_data0, exp_b);
                end
                delivered++;
            end
            @(posedge clk);
            #1;
            if (!uart_en) begin
                model_ready = 1'b1;
                model_busy  = 1'b0;
                busy_left   = 0;
                stall_left  = 0;
            end else if (hs) begin
                model_busy  = 1'b1;
                model_ready = 1'b0;
                busy_left   = tx_len;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    model_busy = 1'b0;
                    stall_left = stall_len;
                    if (stall_len == 0) model_ready = 1'b1;
                end
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) model_ready = 1'b1;
            end
        end
    end

    // Continuous pin-relationship monitor and DE edge counters.
    initial begin : pin_monitor
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (re_n0 !== de0) mon_err++;
                if (re_n1 !== 1'b0) mon_err++;
                if (te0 !== 1'b0) mon_err++;
                if (te1 !== 1'b1) mon_err++;
                if (dir_busy0 !== de0) mon_err++;
                if (de1 !== de0 || dir_busy1 !== dir_busy0) mon_err++;
                if (out_valid1 !== out_valid0 || in_ready1 !== in_ready0) mon_err++;
                if (out_data1 !== out_data0) mon_err++;
                if (de0 && !prev_de) de_rises++;
                if (!de0 && prev_de) de_falls++;
                prev_de = de0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int k;
        int r0;
        int f0;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h66, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h88, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b1};

        // Reset, then ten idle cycles.
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_de", de0, 0);
            checkOutput("idle_re_n", re_n0, 0);
            checkOutput("idle_te", te0, 0);
            checkOutput("idle_in_ready", in_ready0, 0);
            checkOutput("idle_out_valid", out_valid0, 0);
            checkOutput("idle_dir_busy", dir_busy0, 0);
        end
        @(posedge clk);
        #1;

        // Idle vectors: nothing accepted, tx_busy ignored.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end
        applyStimulus('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        checkOutput("idle_busy_ignored_de", de0, 0);
        @(posedge clk);
        #1;

        // Single byte: DE one cycle after in_valid, offer SETUP cycles later.
        uart_en   = 1'b1;
        tx_len    = 100;
        stall_len = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        checkOutput("single_de_before", de0, 0);
        @(posedge clk);
        #1;
        checkOutput("single_de_rise", de0, 1);
        checkOutput("single_no_early_valid", out_valid0, 0);
        k = 0;
        while (!out_valid0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("single_setup_len", k, SETUP);
        checkOutput("single_out_data", out_data0, 8'hA5);
        waitHandshake("single");
        in_valid = 1'b0;
        waitBusyFall("single");
        measureHold(k);
        checkOutput("single_hold_len", k, HOLD);
        checkOutput("single_re_n_after", re_n0, 0);
        checkOutput("single_dir_busy_after", dir_busy0, 0);

        // Back-to-back bytes with 3-cycle ready stalls.
        tx_len    = 5;
        stall_len = 3;
        r0 = de_rises;
        f0 = de_falls;
        @(posedge clk);
        #1;
        for (int b = 1; b <= 4; b++) begin
            sendByte(8'(b));
        end
        in_valid = 1'b0;
        waitBusyFall("b2b");
        waitIdle("b2b");
        checkOutput("b2b_de_rises", de_rises - r0, 1);
        checkOutput("b2b_de_falls", de_falls - f0, 1);
        checkOutput("b2b_queue_empty", exp_q.size(), 0);

        // New byte ten cycles into HOLD resumes without a setup period.
        tx_len    = 20;
        stall_len = 0;
        r0 = de_rises;
        f0 = de_falls;
        @(posedge clk);
        #1;
        sendByte(8'h5A);
        in_valid = 1'b0;
        waitBusyFall("resend");
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        exp_q.push_back(8'h3C);
        @(posedge clk);
        #1;
        checkOutput("resend_out_valid", out_valid0, 1);
        checkOutput("resend_out_data", out_data0, 8'h3C);
        checkOutput("resend_de", de0, 1);
        waitHandshake("resend");
        in_valid = 1'b0;
        waitBusyFall("resend2");
        measureHold(k);
        checkOutput("resend_hold_len", k, HOLD);
        checkOutput("resend_de_rises", de_rises - r0, 1);
        checkOutput("resend_de_falls", de_falls - f0, 1);

        // New byte on the very cycle the HOLD counter reaches zero.
        r0 = de_rises;
        @(posedge clk);
        #1;
        sendByte(8'h99);
        in_valid = 1'b0;
        waitBusyFall("tie");
        @(posedge clk);
        repeat (HOLD - 1) @(posedge clk);
        #1;
        checkOutput("tie_de_last_hold", de0, 1);
        in_valid = 1'b1;
        in_data  = 8'h42;
        exp_q.push_back(8'h42);
        @(posedge clk);
        #1;
        checkOutput("tie_de_kept", de0, 1);
        checkOutput("tie_send", out_valid0, 1);
        waitHandshake("tie");
        in_valid = 1'b0;
        waitBusyFall("tie2");
        waitIdle("tie");
        checkOutput("tie_de_rises", de_rises - r0, 1);

        // SEND-state vectors with a manually driven UART.
        uart_en   = 1'b0;
        man_ready = 1'b0;
        man_busy  = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        k = 0;
        while (!out_valid0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("man_setup_len", k, SETUP + 1);
        for (int i = 4; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Reset while in SEND.
        reset     = 1'b1;
        man_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_no_valid", out_valid0, 0);
        checkOutput("rst_no_ready", in_ready0, 0);
        @(posedge clk);
        #1;
        checkOutput("rst_de", de0, 0);
        checkOutput("rst_re_n", re_n0, 0);
        checkOutput("rst_out_valid", out_valid0, 0);
        checkOutput("rst_dir_busy", dir_busy0, 0);
        checkOutput("rst_re_n_echo", re_n1, 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_de", de0, 0);

        // A one-cycle in_valid pulse still runs the whole sequence.
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("setup_ignores_valid_de", de0, 1);
        checkOutput("setup_ignores_valid_busy", dir_busy0, 1);
        waitIdle("pulse");
        checkOutput("pulse_back_idle", de0, 0);

        // Final bookkeeping.
        checkOutput("delivered_bytes", delivered, 9);
        checkOutput("sb_queue_empty", exp_q.size(), 0);
        checkOutput("monitor_errors", mon_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rs485_dir_ctrl.md
Name: rs485_dir_ctrl

Overview:
- Half-duplex direction sequencer for the fejkon RS-422/485 transceiver.
- Sits between the byte source (Avalon-ST style) and the UART transmitter.
- Drives the transceiver pins `de`, `re_n` and `te` around each transmit burst:
  - asserts the driver and waits a setup time before the first byte;
  - holds the bus until the UART finishes the last stop bit plus a turnaround time;
  - then releases the bus and re-enables the receiver.

Parameters:
- SETUP_CYCLES, 16: number of cycles DE is high before the first byte is offered to the UART. Must be ≥1.
- HOLD_CYCLES, 32: number of cycles DE stays high after the UART goes idle. Must be ≥1.
- RX_DURING_TX, 0: 1 keeps the receiver enabled while driving (echo allowed); 0 forces `re_n` high while DE is high.
- TERM_EN, 0: static value of `rs422_te`; 1 enables the 120 Ohm termination.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  8  byte from the source
- in_valid  in  1  source byte valid
- in_ready  out  1  controller accepts the byte
- out_data  out  8  byte to the UART TX
- out_valid  out  1  byte valid to the UART
- out_ready  in  1  UART accepts the byte
- tx_busy  in  1  UART shifter busy. Contract: high from the cycle after an out handshake until the stop bit completes.
- rs422_re_n  out  1  receiver enable, active low
- rs422_de  out  1  driver enable
- rs422_te  out  1  termination enable
- dir_busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous, active-high.
- Reset values:
  - state = IDLE, counter = 0;
  - `rs422_de` = 0, `rs422_re_n` = 0, `rs422_te` = TERM_EN;
  - `in_ready` = 0, `out_valid` = 0, `dir_busy` = 0.
- `rs422_de`, `rs422_re_n` and `dir_busy` are registered. They are decoded from the next state, so they change on the same edge as the state.
- `rs422_re_n` = `rs422_de` when RX_DURING_TX=0, else constant 0.
- `rs422_te` is constant TERM_EN.
- Data path is combinational pass-through, gated by state:
  - `out_data` = `in_data` always;
  - `out_valid` = `in_valid` and (state == SEND);
  - `in_ready` = `out_ready` and (state == SEND).
- Counter width: $clog2(max(SETUP_CYCLES, HOLD_CYCLES)+1), unsigned, loaded on state entry, decrements to 0, no wrap.
- States:
  - IDLE: DE=0.
    - `in_valid` = 1 → SETUP, counter = SETUP_CYCLES-1.
    - Nothing is accepted in IDLE.
  - SETUP: DE=1, no handshakes.
    - counter == 0 → SEND; else decrement.
    - Exactly SETUP_CYCLES cycles with DE=1 precede the first possible handshake.
    - Deasserting `in_valid` here has no effect: sequencing continues.
  - SEND: DE=1, pass-through active.
    - `in_valid` = 0 → DRAIN.
    - A stalled handshake (`in_valid`=1, `out_ready`=0) stays in SEND.
  - DRAIN: DE=1, no handshakes.
    - `tx_busy` = 0 → HOLD, counter = HOLD_CYCLES-1.
    - DRAIN is entered ≥1 cycle after the last handshake, so `tx_busy` is already valid there.
  - HOLD: DE=1.
    - `in_valid` = 1 → SEND, with no new setup. This takes priority over counter expiry in the same cycle.
    - Else counter == 0 → IDLE (DE drops, `re_n` drops on the same edge).
    - Else decrement.
- Reset mid-burst: DE drops at the reset edge.
  - The byte in the UART may be truncated; this is accepted.
  - No handshake occurs while reset is high.
- `tx_busy` high in IDLE is ignored; DE stays 0.

Test Plan:
- Reset, then idle 10 cycles: `de`=0, `re_n`=0, `te`=TERM_EN, `in_ready`=0, `dir_busy`=0.
- Single byte 0xA5 with SETUP_CYCLES=16:
  - DE rises 1 cycle after `in_valid`;
  - first `out_valid`=1 exactly 16 cycles later; `out_data`=0xA5;
  - UART model holds `tx_busy` 100 cycles; DE falls exactly HOLD_CYCLES (32) cycles after `tx_busy` falls;
  - `re_n` mirrors DE.
- Back-to-back bytes 0x01..0x04 with `out_ready` stalls of 3 cycles: all 4 delivered in order, no drops or duplicates, DE continuous, a single SETUP period.
- New byte in HOLD (10 cycles after idle):
  - returns to SEND next cycle with no setup delay;
  - DE never drops;
  - DE falls HOLD_CYCLES after the second burst's `tx_busy` falls.
- `in_valid` and final HOLD counter==0 in the same cycle: SEND wins, DE stays 1.
- Reset asserted in SEND with RX_DURING_TX=0: next edge `de`=0, `re_n`=0, `out_valid`=0. Repeat with RX_DURING_TX=1: `re_n`=0 throughout the burst.
